// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, access modes and store-buffer entry type
package mem_pkg;

    localparam int BYTE_BITS  = 8;
    localparam int HWORD_BITS = 16;
    localparam int WORD_BITS  = 32;
    localparam int DWORD_BITS = 64;

    localparam int SB_ADDR_BITS = 20;
    localparam int SB_DATA_BITS = DWORD_BITS;

    // funct3 load/store access mode
    typedef enum logic [2:0] {
        MODE_B  = 3'b000,
        MODE_H  = 3'b001,
        MODE_W  = 3'b010,
        MODE_D  = 3'b011,
        MODE_BU = 3'b100,
        MODE_HU = 3'b101,
        MODE_WU = 3'b110
    } mode_e;

    // Store buffer entry at the default geometry
    typedef struct packed {
        logic [SB_ADDR_BITS-1:0] addr;
        logic [2:0]              mode;
        logic [SB_DATA_BITS-1:0] wdata;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// rtl/sb_fifo.sv - in-order store FIFO with per-entry address compare
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   push, push_addr/mode/wdata enqueue one store at tail
//   pop                       retire the head entry
//   cmp_addr, hit             any valid entry targets cmp_addr
//   count                     number of pending entries
//   head_addr/mode/wdata      oldest pending entry
module sb_fifo
    import mem_pkg::*;
#(
    parameter int MEM_BITS  = SB_ADDR_BITS,
    parameter int DATA_SIZE = SB_DATA_BITS,
    parameter int DEPTH     = 4,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [MEM_BITS-1:0]  push_addr,
    input  logic [2:0]           push_mode,
    input  logic [DATA_SIZE-1:0] push_wdata,
    input  logic                 pop,
    input  logic [MEM_BITS-1:0]  cmp_addr,
    output logic                 hit,
    output logic [CW-1:0]        count,
    output logic [MEM_BITS-1:0]  head_addr,
    output logic [2:0]           head_mode,
    output logic [DATA_SIZE-1:0] head_wdata
);

    typedef struct packed {
        logic [MEM_BITS-1:0]  addr;
        logic [2:0]           mode;
        logic [DATA_SIZE-1:0] wdata;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  match;
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;

    // Payload carries no reset: valid bits alone decide what is pending.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{addr: push_addr, mode: push_mode, wdata: push_wdata};
        end
    end

    // push and pop never target the same slot: push needs a non-full
    // buffer and pop a non-empty one, so head != tail whenever both fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + AW'(1);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Mode is ignored: any pending store to the same index is a conflict.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (entries[i].addr == cmp_addr);
        end
    end

    assign hit        = |match;
    assign head_addr  = entries[head].addr;
    assign head_mode  = entries[head].mode;
    assign head_wdata = entries[head].wdata;

endmodule

// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - store buffer between MEM stage and data memory
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/we/addr/mode/wdata    MEM-stage request (we=1 store)
//   req_ready                       request accepted this cycle
//   load_valid, load_data           registered load result
//   sb_empty                        no pending stores
//   mem_we/address/mode/wdata       data memory port
//   mem_rdata                       data memory combinational read data
module mem_store_buffer
    import mem_pkg::*;
#(
    parameter int MEM_BITS  = SB_ADDR_BITS,
    parameter int DATA_SIZE = DWORD_BITS,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [MEM_BITS-1:0]  req_addr,
    input  logic [2:0]           req_mode,
    input  logic [DATA_SIZE-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 load_valid,
    output logic [DATA_SIZE-1:0] load_data,
    output logic                 sb_empty,
    output logic                 mem_we,
    output logic [MEM_BITS-1:0]  mem_address,
    output logic [2:0]           mem_mode,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic                 hit;
    logic [CW-1:0]        count;
    logic [MEM_BITS-1:0]  head_addr;
    logic [2:0]           head_mode;
    logic [DATA_SIZE-1:0] head_wdata;

    logic full;
    logic load_owns_port;
    logic load_go;
    logic store_go;
    logic drain;

    assign full           = (count == FULL);
    assign load_owns_port = req_valid && !req_we && !hit;
    assign load_go        = load_owns_port && !full;
    assign store_go       = req_valid && req_we && !full;
    // A full buffer always drains, so back-to-back loads cannot starve it.
    assign drain          = full || (!load_owns_port && (count != '0));

    assign req_ready = load_go || store_go;
    assign sb_empty  = (count == '0);

    // Gated by rst so a store discarded by reset never reaches memory.
    assign mem_we      = drain && !rst;
    assign mem_address = drain ? head_addr  : req_addr;
    assign mem_mode    = drain ? head_mode  : req_mode;
    assign mem_wdata   = drain ? head_wdata : req_wdata;

    sb_fifo #(
        .MEM_BITS  (MEM_BITS),
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (store_go),
        .push_addr  (req_addr),
        .push_mode  (req_mode),
        .push_wdata (req_wdata),
        .pop        (drain),
        .cmp_addr   (req_addr),
        .hit        (hit),
        .count      (count),
        .head_addr  (head_addr),
        .head_mode  (head_mode),
        .head_wdata (head_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            load_valid <= 1'b0;
            load_data  <= '0;
        end else begin
            load_valid <= load_go;
            if (load_go) begin
                load_data <= mem_rdata;
            end
        end
    end

endmodule
